demux_router: RTL

Packet-level 1-to-2 demultiplexer with valid/ready handshakes. It steers a single input stream to output port A or B according to a select bit sampled on the first beat of each packet. The selection holds until that packet's last beat is accepted. It sits downstream of a stream source and is the return-path counterpart of the team's 2:1 mux, splitting one stream into two. Each output has a one-entry output register and a per-port packet counter.

---
 rtl/demux_router.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
// Module      : demux_router
// Description : Packet-level 1-to-2 stream demultiplexer. The destination
//               (A or B) is taken from in_sel on the first beat of a packet
//               and held until the packet's last beat is accepted. Each
//               output port has a one-entry output register and a packet
//               counter that steps when a last beat is accepted for it.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid/ready/data/sel/last - input stream
//               a_valid/ready/data/last      - output stream A
//               b_valid/ready/data/last      - output stream B
//               cnt_a, cnt_b                 - completed-packet counters
// Revision    : 1.0 - initial release
// ============================================================================
module demux_router #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUTE_A = 2'd1,
        ST_ROUTE_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_a_valid;
    logic [WIDTH-1:0] r_a_data;
    logic             r_a_last;
    logic             r_b_valid;
    logic [WIDTH-1:0] r_b_data;
    logic             r_b_last;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic             w_target_b;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_load_a;
    logic             w_load_b;

    // Destination: live in_sel only between packets, otherwise locked.
    always_comb begin
        w_target_b = 1'b0;
        case (r_state)
            ST_IDLE:    w_target_b = in_sel;
            ST_ROUTE_A: w_target_b = 1'b0;
            ST_ROUTE_B: w_target_b = 1'b1;
            default:    w_target_b = 1'b0;
        endcase
    end

    // Ready looks only at the target port so an idle-side stall never
    // blocks traffic headed to the other port.
    assign w_in_ready = w_target_b ? (!r_b_valid || b_ready)
                                   : (!r_a_valid || a_ready);
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_load_a   = w_in_xfer && !w_target_b;
    assign w_load_b   = w_in_xfer &&  w_target_b;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_xfer && !in_last) begin
                    w_state_nxt = in_sel ? ST_ROUTE_B : ST_ROUTE_A;
                end
            end
            ST_ROUTE_A, ST_ROUTE_B: begin
                if (w_in_xfer && in_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Port A output register: a load wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_last  <= 1'b0;
        end else if (w_load_a) begin
            r_a_valid <= 1'b1;
            r_a_data  <= in_data;
            r_a_last  <= in_last;
        end else if (r_a_valid && a_ready) begin
            r_a_valid <= 1'b0;
        end
    end

    // Port B output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_last  <= 1'b0;
        end else if (w_load_b) begin
            r_b_valid <= 1'b1;
            r_b_data  <= in_data;
            r_b_last  <= in_last;
        end else if (r_b_valid && b_ready) begin
            r_b_valid <= 1'b0;
        end
    end

    // Counters step when the last beat enters the block, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_load_a && in_last) begin
                r_cnt_a <= r_cnt_a + 1'b1;
            end
            if (w_load_b && in_last) begin
                r_cnt_b <= r_cnt_b + 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign a_valid  = r_a_valid;
    assign a_data   = r_a_data;
    assign a_last   = r_a_last;
    assign b_valid  = r_b_valid;
    assign b_data   = r_b_data;
    assign b_last   = r_b_last;
    assign cnt_a    = r_cnt_a;
    assign cnt_b    = r_cnt_b;

endmodule
`default_nettype wire
